// File: rtl/vram_arbiter.sv
// Video-RAM arbiter: strict-priority display reads over a 4-deep host write FIFO on one single-port RAM.
// Optional stall counter output enabled by defining VRAM_ARB_STALL_CNT_EN.
module vram_arbiter #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 24
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_data_vld,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    fifo_cnt
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned SW    = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ent_t;

  wr_ent_t       fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    rd_pipe_q, rd_pipe_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] disp_data_q, disp_data_d;

  logic push_c;
  logic rd_gnt_c;
  logic wr_gnt_c;

  // Arbitration decisions use occupancy at cycle start, so a fresh push cannot be granted this cycle.
  assign wr_ready = !reset && (cnt_q != CW'(DEPTH));
  assign push_c   = wr_valid && wr_ready;
  assign rd_gnt_c = disp_req;
  assign wr_gnt_c = !disp_req && (cnt_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CW'(push_c) - CW'(wr_gnt_c);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_pipe_d   = {rd_pipe_q[0], rd_gnt_c};
    vld_d       = rd_pipe_q[1];
    disp_data_d = disp_data_q;

    if (rd_gnt_c) begin
      mem_addr_d = disp_addr;
    end else if (wr_gnt_c) begin
      mem_addr_d  = fifo_q[rd_ptr_q].addr;
      mem_wdata_d = fifo_q[rd_ptr_q].data;
      mem_we_d    = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    // RAM data for a read granted two edges ago is on mem_rdata now.
    if (rd_pipe_q[1]) begin
      disp_data_d = mem_rdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_pipe_q   <= '0;
      vld_q       <= 1'b0;
      disp_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_pipe_q   <= rd_pipe_d;
      vld_q       <= vld_d;
      disp_data_q <= disp_data_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge pclk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign disp_data     = disp_data_q;
  assign disp_data_vld = vld_q;
  assign fifo_cnt      = cnt_q;

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [SW-1:0] stall_q, stall_d;

  // Counts cycles where a display read blocks queued writes; saturates.
  always_comb begin
    stall_d = stall_q;
    if (disp_req && (cnt_q != '0) && (stall_q != {SW{1'b1}})) begin
      stall_d = stall_q + SW'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized + directed bench for vram_arbiter against a queue-based transaction model.
// Define VRAM_ARB_STALL_CNT_EN to also exercise the stall counter.
module tb_vram_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 24;
  localparam int unsigned NW = 1 << AW;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_data_vld;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    fifo_cnt;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 pclk = ~pclk;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .pclk          (pclk),
    .reset         (reset),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_data     (disp_data),
    .disp_data_vld (disp_data_vld),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .fifo_cnt      (fifo_cnt)
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // Single-port synchronous RAM: read data appears one cycle after the address.
  logic [DW-1:0] ram [NW];
  always @(posedge pclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } went_t;

  typedef struct packed {
    int unsigned   due;
    logic [DW-1:0] d;
  } rret_t;

  went_t         fq[$];
  rret_t         rq[$];
  logic [DW-1:0] shadow [NW];
  int unsigned   edge_n = 0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_vld = 1'b0;
  logic [DW-1:0] exp_data = '0;
  int unsigned   exp_stall = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  // Advance the transaction model across the upcoming edge using the inputs now applied.
  task automatic model_step();
    went_t ent;
    rret_t r;
    logic  accept;
    edge_n++;
    if (reset) begin
      fq.delete();
      rq.delete();
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_vld = 1'b0; exp_data = '0; exp_stall = 0;
    end else begin
      accept = wr_valid && (fq.size() != 4);
      if (disp_req && fq.size() != 0 && exp_stall != 65535) exp_stall++;
      if (disp_req) begin
        exp_we = 1'b0;
        exp_addr = disp_addr;
        r.due = edge_n + 2;
        r.d = shadow[disp_addr];
        rq.push_back(r);
      end else if (fq.size() != 0) begin
        ent = fq.pop_front();
        shadow[ent.a] = ent.d;
        exp_we = 1'b1;
        exp_addr = ent.a;
        exp_wdata = ent.d;
      end else begin
        exp_we = 1'b0;
      end
      if (accept) begin
        ent.a = wr_addr;
        ent.d = wr_data;
        fq.push_back(ent);
      end
      exp_vld = 1'b0;
      if (rq.size() != 0 && rq[0].due == edge_n) begin
        exp_vld = 1'b1;
        exp_data = rq[0].d;
        void'(rq.pop_front());
      end
    end
  endtask

  task automatic check_all();
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check("disp_data_vld", 32'(disp_data_vld), 32'(exp_vld));
    check("disp_data", 32'(disp_data), 32'(exp_data));
    check("fifo_cnt", 32'(fifo_cnt), 32'(fq.size()));
    check("wr_ready", 32'(wr_ready), 32'(!reset && fq.size() != 4));
`ifdef VRAM_ARB_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge pclk);
    @(negedge pclk);
    check_all();
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    wr_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < int'(NW); i++) begin
      ram[i] = DW'(i);
      shadow[i] = DW'(i);
    end

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

`ifdef VRAM_ARB_STALL_CNT_EN
    disp_req = 1'b1; disp_addr = AW'(7);
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = DW'(24'h123456);
    step();
    wr_valid = 1'b0;
    repeat (10) step();
    check("stall_10", 32'(stall_cnt), 32'd10);
    idle(4);
`endif

    // Back-to-back reads of words 0..4
    for (int i = 0; i < 5; i++) begin
      disp_req = 1'b1;
      disp_addr = AW'(i);
      step();
    end
    idle(5);

    // Single write, then read it back
    wr_valid = 1'b1; wr_addr = AW'(12'h010); wr_data = DW'(24'hFF0000);
    step();
    idle(3);
    disp_req = 1'b1; disp_addr = AW'(12'h010);
    step();
    idle(4);

    // Reads starve writes; FIFO fills to 4 and the fifth offer is refused
    disp_req = 1'b1; disp_addr = AW'(3);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr = AW'(12'h100 + i);
      wr_data = DW'(24'hA00000 + i);
      step();
    end
    wr_valid = 1'b0;
    check("fifo_full", 32'(fifo_cnt), 32'd4);
    check("wr_ready_full", 32'(wr_ready), 32'd0);
    repeat (3) step();
    idle(7);

    // Simultaneous push and pop at occupancy 2
    disp_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_addr = AW'(12'h200 + i);
      wr_data = DW'(24'hB00000 + i);
      step();
    end
    disp_req = 1'b0;
    wr_addr = AW'(12'h202); wr_data = DW'(24'hB00002);
    step();
    check("cnt_pushpop", 32'(fifo_cnt), 32'd2);
    idle(4);

    // Reset with 3 queued writes and reads in flight
    disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp_addr = AW'(i + 1);
      wr_valid = 1'b1;
      wr_addr = AW'(12'h300 + i);
      wr_data = DW'(24'hC00000 + i);
      step();
    end
    disp_req = 1'b0; wr_valid = 1'b0; reset = 1'b1;
    step();
    check("cnt_after_rst", 32'(fifo_cnt), 32'd0);
    reset = 1'b0;
    idle(6);

    // Random traffic on a small address window to provoke same-address hazards
    for (int n = 0; n < 500; n++) begin
      disp_req = ($urandom_range(4) < 2);
      disp_addr = AW'($urandom_range(15));
      wr_valid = $urandom_range(1) == 1;
      wr_addr = AW'($urandom_range(15));
      wr_data = DW'($urandom);
      reset = ($urandom_range(96) == 0);
      step();
    end
    reset = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
